eth_ipv4_header_builder: RTL and testbench

Transmit-side counterpart of the Ethernet/IPv4 header parser. It accepts one Ethernet header and one IPv4 header per packet, plus an AXI-Stream payload. It emits a single AXI-Stream frame carrying the 14-byte Ethernet header, the 20-byte IPv4 header and the payload re-aligned behind them. The builder computes IPv4 total_length and header checksum itself. It sits between the payload source (UDP/TCP framer) and the MAC TX interface.

---
 rtl/eth_ipv4_header_builder_pkg.sv | 58 +++++
 rtl/eth_ipv4_header_builder_csum.sv | 21 ++
 rtl/eth_ipv4_header_builder.sv | 175 +++++++++++++++++
 tb/tb_eth_ipv4_header_builder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_ipv4_header_builder_pkg.sv
// Shared types, constants and byte helpers for the Ethernet/IPv4 header builder.
package eth_ipv4_header_builder_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int IPV4_HDR_LEN = 20;
  localparam int HDR_BYTES = ETH_HDR_LEN + IPV4_HDR_LEN;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IPV4_VER_IHL = 8'h45;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } eth_header_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] total_length;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_header_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR,
    ST_MERGE,
    ST_FLUSH
  } bld_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(k[i]);
    return n;
  endfunction

  function automatic logic [7:0] low_mask(input logic [3:0] n);
    return 8'((16'd1 << n) - 16'd1);
  endfunction

  // Big-endian 8-byte word (first byte in MSBs) to stream order (first byte in [7:0]).
  function automatic logic [63:0] be_to_stream(input logic [63:0] be);
    logic [63:0] s;
    for (int i = 0; i < 8; i++) s[8*i +: 8] = be[63-8*i -: 8];
    return s;
  endfunction

endpackage

// File: rtl/eth_ipv4_header_builder_csum.sv
// Combinational IPv4 header checksum; the caller zeroes the checksum field.
module ipv4_checksum
  import eth_ipv4_header_builder_pkg::*;
(
  input  logic [159:0] hdr,
  output logic [15:0]  csum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + 20'(hdr[159-16*i -: 16]);
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum = ~fold2;
  end

endmodule

// File: rtl/eth_ipv4_header_builder.sv
// Prepends a 14-byte Ethernet and 20-byte IPv4 header to a 64-bit AXI-Stream payload.
// state | meaning
// IDLE  | waiting for header descriptor
// CSUM  | registering the IPv4 checksum
// HDR   | emitting header bytes 0-31 (4 beats)
// MERGE | payload shifted 2 bytes behind header bytes 32-33
// FLUSH | trailing residual bytes of the last payload beat
module eth_ipv4_header_builder
  import eth_ipv4_header_builder_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  eth_header_t           eth_hdr,
  input  ipv4_header_t          ipv4_hdr,
  input  logic [15:0]           payload_len,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  pkt_done,
  output logic                  len_err
);

  if (DATA_W != 64) begin : g_bad_width
    $error("eth_ipv4_header_builder supports only DATA_W=64");
  end

  bld_state_t   state_q, state_d;
  eth_header_t  eth_q;
  ipv4_header_t ipv4_q, ipv4_fix, ipv4_out;
  logic [15:0]  plen_q, csum_q, csum_w, resid_q, byte_cnt_q, final_cnt;
  logic [1:0]   beat_q;
  logic [7:0]   flush_keep_q;
  logic         pkt_done_q, len_err_q;
  logic [3:0]   s_pop;
  logic         m_hs, s_hs, final_hs;
  logic [8*HDR_BYTES-1:0] hdr_vec;
  logic [63:0]  hdr_be;

  always_comb begin
    ipv4_fix = ipv4_q;
    ipv4_fix.version = IPV4_VER_IHL[7:4];
    ipv4_fix.ihl = IPV4_VER_IHL[3:0];
    ipv4_fix.total_length = plen_q + 16'(IPV4_HDR_LEN);
    ipv4_fix.checksum = '0;
    ipv4_out = ipv4_fix;
    ipv4_out.checksum = csum_q;
  end

  ipv4_checksum u_csum (
    .hdr  (ipv4_fix),
    .csum (csum_w)
  );

  assign hdr_vec = {eth_q.dst_mac, eth_q.src_mac, ETHERTYPE_IPV4, ipv4_out};

  always_comb begin
    case (beat_q)
      2'd0:    hdr_be = hdr_vec[271:208];
      2'd1:    hdr_be = hdr_vec[207:144];
      2'd2:    hdr_be = hdr_vec[143:80];
      default: hdr_be = hdr_vec[79:16];
    endcase
  end

  assign s_pop = popcount8(s_axis_tkeep);
  assign m_hs = m_axis_tvalid & m_axis_tready;
  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign final_hs = m_hs & m_axis_tlast;
  assign final_cnt = (state_q == ST_MERGE) ? byte_cnt_q + 16'(s_pop) : byte_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hdr_valid) state_d = ST_CSUM;
      ST_CSUM:  state_d = ST_HDR;
      ST_HDR:   if (m_hs && beat_q == 2'd3) state_d = ST_MERGE;
      ST_MERGE: if (s_hs && s_axis_tlast) state_d = (s_pop <= 4'd6) ? ST_IDLE : ST_FLUSH;
      ST_FLUSH: if (m_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    case (state_q)
      ST_IDLE: hdr_ready = 1'b1;
      ST_HDR: begin
        m_axis_tdata = be_to_stream(hdr_be);
        m_axis_tkeep = 8'hFF;
        m_axis_tvalid = 1'b1;
      end
      ST_MERGE: begin
        m_axis_tdata = {s_axis_tdata[47:0], resid_q};
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tkeep = 8'hFF;
        if (s_axis_tlast && s_pop <= 4'd6) begin
          m_axis_tkeep = low_mask(s_pop + 4'd2);
          m_axis_tlast = 1'b1;
        end
      end
      ST_FLUSH: begin
        m_axis_tdata = {48'h0, resid_q};
        m_axis_tkeep = flush_keep_q;
        m_axis_tvalid = 1'b1;
        m_axis_tlast = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      eth_q <= '0;
      ipv4_q <= '0;
      plen_q <= '0;
      csum_q <= '0;
      resid_q <= '0;
      byte_cnt_q <= '0;
      beat_q <= '0;
      flush_keep_q <= '0;
      pkt_done_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      pkt_done_q <= final_hs;
      len_err_q <= final_hs && (final_cnt != plen_q);
      case (state_q)
        ST_IDLE: if (hdr_valid) begin
          eth_q <= eth_hdr;
          ipv4_q <= ipv4_hdr;
          plen_q <= payload_len;
          byte_cnt_q <= '0;
          beat_q <= '0;
        end
        ST_CSUM: csum_q <= csum_w;
        ST_HDR: if (m_hs) begin
          beat_q <= beat_q + 2'd1;
          // header bytes 32 (low) and 33 (high) ride in front of the first payload beat
          if (beat_q == 2'd3) resid_q <= {hdr_vec[7:0], hdr_vec[15:8]};
        end
        ST_MERGE: if (s_hs) begin
          resid_q <= s_axis_tdata[63:48];
          byte_cnt_q <= byte_cnt_q + 16'(s_pop);
          if (s_axis_tlast && s_pop > 4'd6) flush_keep_q <= low_mask(s_pop - 4'd6);
        end
        default: ;
      endcase
    end
  end

  assign pkt_done = pkt_done_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_eth_ipv4_header_builder.sv
// Randomized bench for eth_ipv4_header_builder against a byte-level frame model.
module tb_eth_ipv4_header_builder;
  import eth_ipv4_header_builder_pkg::*;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  eth_header_t  eth_hdr = '0;
  ipv4_header_t ipv4_hdr = '0;
  logic [15:0]  payload_len = '0;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tkeep = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic         pkt_done;
  logic         len_err;

  always #5 aclk = ~aclk;

  eth_ipv4_header_builder #(.DATA_W(64)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .eth_hdr(eth_hdr), .ipv4_hdr(ipv4_hdr), .payload_len(payload_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pkt_done(pkt_done), .len_err(len_err)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_beats;
  logic [7:0] last_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_payload(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back(8'($urandom));
  endtask

  task automatic fixed_fields();
    eth_hdr.dst_mac = 48'h0011_2233_4455;
    eth_hdr.src_mac = 48'h6677_8899_aabb;
    eth_hdr.ethertype = 16'h1234;
    ipv4_hdr = '0;
    ipv4_hdr.version = 4'h6;
    ipv4_hdr.ihl = 4'h7;
    ipv4_hdr.total_length = 16'hffff;
    ipv4_hdr.checksum = 16'habcd;
    ipv4_hdr.flags = 3'b010;
    ipv4_hdr.ttl = 8'h40;
    ipv4_hdr.protocol = 8'h11;
    ipv4_hdr.src_ip = 32'hc0a80001;
    ipv4_hdr.dst_ip = 32'hc0a800c7;
  endtask

  task automatic rand_fields();
    eth_hdr = {$urandom, $urandom, $urandom, $urandom};
    ipv4_hdr = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Expected frame: header bytes from the field values, then the payload as sent.
  task automatic build_exp(input int plen);
    int w[10];
    int sum, tl;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(eth_hdr.dst_mac >> (40 - 8*i)));
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(eth_hdr.src_mac >> (40 - 8*i)));
    tl = (plen + 20) % 65536;
    w[0] = 'h4500 + ipv4_hdr.dscp * 4 + ipv4_hdr.ecn;
    w[1] = tl;
    w[2] = ipv4_hdr.id;
    w[3] = ipv4_hdr.flags * 8192 + ipv4_hdr.frag_offset;
    w[4] = ipv4_hdr.ttl * 256 + ipv4_hdr.protocol;
    w[5] = 0;
    w[6] = ipv4_hdr.src_ip / 65536;
    w[7] = ipv4_hdr.src_ip % 65536;
    w[8] = ipv4_hdr.dst_ip / 65536;
    w[9] = ipv4_hdr.dst_ip % 65536;
    sum = 0;
    for (int i = 0; i < 10; i++) sum += w[i];
    while (sum > 'hffff) sum = (sum % 65536) + (sum / 65536);
    w[5] = 'hffff - sum;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'(w[i] / 256));
      exp_q.push_back(8'(w[i] % 256));
    end
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
  endtask

  function automatic logic [63:0] pay_data(input int k);
    logic [63:0] d = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < pay_q.size()) d[8*j +: 8] = pay_q[8*k + j];
    return d;
  endfunction

  function automatic logic [7:0] pay_keep(input int k);
    logic [7:0] m = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < pay_q.size()) m[j] = 1'b1;
    return m;
  endfunction

  function automatic logic mode_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return ($urandom % 4) != 0;
  endfunction

  // mode: 0 ready always, 1 ready toggling, 2 random ready; gaps: random s_tvalid bubbles
  task automatic run_pkt(input int plen, input int mode, input bit gaps);
    int nb, pb, cyc, gb, rem, nbad;
    bit busy, done_next, finished, dhs, shs, mhs;
    logic [7:0] ek;
    build_exp(plen);
    got_q.delete();
    got_beats = 0;
    last_keep = '0;
    nb = (pay_q.size() + 7) / 8;
    pb = 0; cyc = 0; busy = 0; done_next = 0; finished = 0;
    payload_len = 16'(plen);
    hdr_valid = 1'b1;
    m_axis_tready = mode_ready(mode, 0);
    s_axis_tvalid = (nb > 0) && (!gaps || $urandom % 2 == 0);
    s_axis_tdata = pay_data(0);
    s_axis_tkeep = pay_keep(0);
    s_axis_tlast = (nb == 1);
    while (!finished && cyc < 3000) begin
      @(negedge aclk);
      dhs = hdr_valid && hdr_ready;
      shs = s_axis_tvalid && s_axis_tready;
      mhs = m_axis_tvalid && m_axis_tready;
      if (done_next) begin
        chk("pkt_done", 64'(pkt_done), 64'd1);
        chk("len_err", 64'(len_err), 64'(pay_q.size() != plen));
        finished = 1;
      end else if (mode == 1 && busy) begin
        chk("hdr_ready_busy", 64'(hdr_ready), 64'd0);
      end
      if (dhs) busy = 1;
      if (mhs && !finished) begin
        gb = got_beats;
        rem = exp_q.size() - 8*gb;
        ek = (rem >= 8) ? 8'hFF : ((rem > 0) ? 8'((1 << rem) - 1) : 8'h00);
        chk("beat_tkeep", 64'(m_axis_tkeep), 64'(ek));
        chk("beat_tlast", 64'(m_axis_tlast), 64'(rem <= 8));
        for (int j = 0; j < 8; j++)
          if (m_axis_tkeep[j]) got_q.push_back(m_axis_tdata[8*j +: 8]);
        got_beats++;
        last_keep = m_axis_tkeep;
        if (m_axis_tlast) done_next = 1;
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (dhs) hdr_valid = 1'b0;
      if (shs) pb++;
      if (pb < nb) begin
        if (shs || !s_axis_tvalid) s_axis_tvalid = !gaps || ($urandom % 2 == 0);
        s_axis_tdata = pay_data(pb);
        s_axis_tkeep = pay_keep(pb);
        s_axis_tlast = (pb == nb - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
      end
      m_axis_tready = mode_ready(mode, cyc);
    end
    if (!finished) chk("timeout", 64'd0, 64'd1);
    hdr_valid = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    chk("frame_len", 64'(got_q.size()), 64'(exp_q.size()));
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        if (nbad == 0) $display("FAIL frame_byte[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
        nbad++;
      end
    chk("frame_bad_bytes", 64'(nbad), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hdr_ready"}, 64'(hdr_ready), 64'd1);
    chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_m_tkeep"}, 64'(m_axis_tkeep), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
    chk({tag, "_len_err"}, 64'(len_err), 64'd0);
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // 95 bytes: 11 full beats + tkeep 0x7F
    fixed_fields();
    make_payload(95);
    run_pkt(95, 0, 0);
    chk("beats_95", 64'(got_beats), 64'd17);
    chk("last_keep_95", 64'(last_keep), 64'h01);
    if (got_q.size() >= 26) begin
      chk("ethertype", 64'({got_q[12], got_q[13]}), 64'h0800);
      chk("total_len", 64'({got_q[16], got_q[17]}), 64'h0073);
      chk("checksum", 64'({got_q[24], got_q[25]}), 64'hb861);
    end else chk("short_frame_95", 64'(got_q.size()), 64'd129);

    make_payload(6);
    run_pkt(6, 0, 0);
    chk("beats_6", 64'(got_beats), 64'd5);
    chk("last_keep_6", 64'(last_keep), 64'hFF);

    make_payload(1);
    run_pkt(1, 0, 0);
    chk("beats_1", 64'(got_beats), 64'd5);
    chk("last_keep_1", 64'(last_keep), 64'h07);

    // toggling backpressure on the 95-byte packet
    make_payload(95);
    run_pkt(95, 1, 0);
    chk("beats_95_bp", 64'(got_beats), 64'd17);

    // declared 20, only 16 delivered
    make_payload(16);
    run_pkt(20, 0, 0);
    chk("frame_len_short", 64'(got_q.size()), 64'd50);

    // async reset in the middle of MERGE
    fixed_fields();
    make_payload(24);
    payload_len = 16'd24;
    s_axis_tdata = pay_data(0);
    s_axis_tkeep = pay_keep(0);
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    hdr_valid = 1'b1;
    @(posedge aclk);
    #1;
    hdr_valid = 1'b0;
    for (int i = 0; i < 20 && !s_axis_tready; i++) @(negedge aclk);
    chk("merge_reached", 64'(s_axis_tready), 64'd1);
    #1;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midpkt_reset");
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    make_payload(6);
    run_pkt(6, 0, 0);
    chk("beats_after_reset", 64'(got_beats), 64'd5);

    // randomized packets under random backpressure and source bubbles
    for (int n = 0; n < 25; n++) begin
      int plen, sent;
      rand_fields();
      plen = 1 + int'($urandom % 40);
      sent = ($urandom % 5 == 0) ? 1 + int'($urandom % 40) : plen;
      make_payload(sent);
      run_pkt(plen, 2, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
